// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - PL011 register offsets, TXFF bit index and streamer FSM states
package uart_pkg;

  localparam logic [11:0] UART_DR   = 12'h000;
  localparam logic [11:0] UART_FR   = 12'h018;
  localparam logic [11:0] UART_IBRD = 12'h024;
  localparam logic [11:0] UART_FBRD = 12'h028;
  localparam logic [11:0] UART_LCRH = 12'h02C;
  localparam logic [11:0] UART_CR   = 12'h030;

  localparam int TXFF_BIT = 5;

  typedef enum logic [2:0] {
    INIT_SETUP,
    INIT_ACCESS,
    IDLE,
    POLL_SETUP,
    POLL_ACCESS,
    WR_SETUP,
    WR_ACCESS
  } state_e;

endpackage

// File: rtl/uart_tx_streamer.sv
// rtl/uart_tx_streamer.sv - APB master that configures a PL011 and streams bytes to UARTDR
// Optional TX-FIFO-full polling and stall detection: UART_TX_STREAMER_FLOWCTL_EN
module uart_tx_streamer
  import uart_pkg::*;
#(
  parameter logic [15:0] IBRD_INIT  = 16'd27,
  parameter logic [5:0]  FBRD_INIT  = 6'd8,
  parameter logic [15:0] LCRH_INIT  = 16'h0070,
  parameter logic [15:0] CR_INIT    = 16'h0301,
  parameter logic [7:0]  POLL_LIMIT = 8'd255
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [11:0] PADDR,
  output logic [15:0] PWDATA,
  input  logic [15:0] PRDATA,
  output logic        init_done,
  output logic        tx_stall
);

  state_e      state, state_d;
  logic [1:0]  idx, idx_d;
  logic [7:0]  hold, hold_d;
  logic        init_d;
  logic        psel_d, penable_d, pwrite_d;
  logic [11:0] paddr_d;
  logic [15:0] pwdata_d;

  assign byte_ready = (state == IDLE) && init_done;

`ifdef UART_TX_STREAMER_FLOWCTL_EN
  logic [7:0] poll_cnt, poll_cnt_d;
  assign tx_stall = (poll_cnt >= POLL_LIMIT);
`else
  logic unused_cfg;
  assign unused_cfg = ^{PRDATA, POLL_LIMIT};
  assign tx_stall   = 1'b0;
`endif

  always_comb begin
    state_d   = state;
    idx_d     = idx;
    hold_d    = hold;
    init_d    = init_done;
`ifdef UART_TX_STREAMER_FLOWCTL_EN
    poll_cnt_d = poll_cnt;
`endif
    psel_d    = 1'b0;
    penable_d = 1'b0;
    pwrite_d  = 1'b0;
    paddr_d   = 12'h000;
    pwdata_d  = 16'h0000;

    case (state)
      // Bus outputs are registered from the next state, so the first cycle
      // after reset is spent loading the IBRD setup phase onto the bus.
      INIT_SETUP: if (PSEL) state_d = INIT_ACCESS;
      INIT_ACCESS: begin
        idx_d = idx + 2'd1;
        if (idx == 2'd3) begin
          state_d = IDLE;
          init_d  = 1'b1;
        end else begin
          state_d = INIT_SETUP;
        end
      end
      IDLE: begin
        if (byte_valid && byte_ready) begin
          hold_d = byte_in;
`ifdef UART_TX_STREAMER_FLOWCTL_EN
          state_d = POLL_SETUP;
`else
          state_d = WR_SETUP;
`endif
        end
      end
`ifdef UART_TX_STREAMER_FLOWCTL_EN
      POLL_SETUP: state_d = POLL_ACCESS;
      POLL_ACCESS: begin
        if (PRDATA[TXFF_BIT]) begin
          poll_cnt_d = (poll_cnt == 8'hFF) ? poll_cnt : poll_cnt + 8'd1;
          state_d    = POLL_SETUP;
        end else begin
          poll_cnt_d = 8'd0;
          state_d    = WR_SETUP;
        end
      end
`endif
      WR_SETUP:  state_d = WR_ACCESS;
      WR_ACCESS: state_d = IDLE;
      default:   state_d = INIT_SETUP;
    endcase

    case (state_d)
      INIT_SETUP, INIT_ACCESS: begin
        psel_d    = 1'b1;
        penable_d = (state_d == INIT_ACCESS);
        pwrite_d  = 1'b1;
        case (idx_d)
          2'd0:    begin paddr_d = UART_IBRD; pwdata_d = IBRD_INIT;          end
          2'd1:    begin paddr_d = UART_FBRD; pwdata_d = {10'd0, FBRD_INIT}; end
          2'd2:    begin paddr_d = UART_LCRH; pwdata_d = LCRH_INIT;          end
          default: begin paddr_d = UART_CR;   pwdata_d = CR_INIT;            end
        endcase
      end
`ifdef UART_TX_STREAMER_FLOWCTL_EN
      POLL_SETUP, POLL_ACCESS: begin
        psel_d    = 1'b1;
        penable_d = (state_d == POLL_ACCESS);
        paddr_d   = UART_FR;
      end
`endif
      WR_SETUP, WR_ACCESS: begin
        psel_d    = 1'b1;
        penable_d = (state_d == WR_ACCESS);
        pwrite_d  = 1'b1;
        paddr_d   = UART_DR;
        pwdata_d  = {8'h00, hold_d};
      end
      default: ;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state     <= INIT_SETUP;
      idx       <= 2'd0;
      hold      <= 8'h00;
      init_done <= 1'b0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= 12'h000;
      PWDATA    <= 16'h0000;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      hold      <= hold_d;
      init_done <= init_d;
      PSEL      <= psel_d;
      PENABLE   <= penable_d;
      PWRITE    <= pwrite_d;
      PADDR     <= paddr_d;
      PWDATA    <= pwdata_d;
    end
  end

`ifdef UART_TX_STREAMER_FLOWCTL_EN
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) poll_cnt <= 8'd0;
    else        poll_cnt <= poll_cnt_d;
  end
`endif

endmodule

// File: tb/tb_uart_tx_streamer.sv
// tb/tb_uart_tx_streamer.sv - directed self-checking bench for uart_tx_streamer
module tb_uart_tx_streamer;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        PSEL, PENABLE, PWRITE;
  logic [11:0] PADDR;
  logic [15:0] PWDATA;
  logic [15:0] PRDATA;
  logic        init_done;
  logic        tx_stall;

  uart_tx_streamer #(.POLL_LIMIT(8'd4)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .init_done(init_done),
    .tx_stall(tx_stall)
  );

  always #5 PCLK = ~PCLK;

`ifdef UART_TX_STREAMER_FLOWCTL_EN
  localparam int EXP_LAT = 4, EXP_WRLAT = 3, EXP_GAP = 5, EXP_RD = 1;
`else
  localparam int EXP_LAT = 2, EXP_WRLAT = 1, EXP_GAP = 3, EXP_RD = 0;
`endif

  typedef struct {
    logic [11:0] addr;
    logic [15:0] data;
    logic        wr;
    int          cyc;
  } xfer_t;

  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc = 0;
  int    rd_cnt = 0;
  int    busy_until = 0;
  int    proto_err = 0;
  xfer_t log_q[$];
  logic        p_psel = 1'b0, p_pen = 1'b0, p_wr = 1'b0;
  logic [11:0] p_addr = 12'h0;
  logic [15:0] p_data = 16'h0;

  // FR model: TXFF reads as set until busy_until reads have completed
  assign PRDATA = (rd_cnt < busy_until) ? 16'h0020 : 16'h0000;

  always @(posedge PCLK) begin
    cyc <= cyc + 1;
    if (PRESET) begin
      p_psel = 1'b0;
      p_pen  = 1'b0;
    end else begin
      if (PSEL && PENABLE) begin
        if (!(p_psel && !p_pen && p_addr == PADDR && p_wr == PWRITE && p_data == PWDATA))
          proto_err++;
        log_q.push_back('{PADDR, PWDATA, PWRITE, cyc});
        if (!PWRITE) rd_cnt <= rd_cnt + 1;
      end
      p_psel = PSEL; p_pen = PENABLE; p_wr = PWRITE; p_addr = PADDR; p_data = PWDATA;
    end
  end

  task automatic count_log(output int nrd, output int nwr);
    nrd = 0; nwr = 0;
    foreach (log_q[i]) begin
      if (log_q[i].wr && log_q[i].addr == 12'h000) nwr++;
      if (!log_q[i].wr && log_q[i].addr == 12'h018) nrd++;
    end
  endtask

  task automatic wait_init(output int icyc);
    int t = 0;
    while (!init_done && t < 100) begin @(negedge PCLK); t++; end
    icyc = cyc;
    n_cmp++;
    if (init_done !== 1'b1) begin $display("FAIL init_timeout: init_done=%b want 1", init_done); n_bad++; end
  endtask

  task automatic put_byte(input logic [7:0] b, output int cap);
    int t = 0;
    while (!byte_ready && t < 2000) begin @(negedge PCLK); t++; end
    n_cmp++;
    if (byte_ready !== 1'b1) begin $display("FAIL ready_timeout: byte_ready=%b want 1", byte_ready); n_bad++; end
    byte_in = b; byte_valid = 1'b1;
    @(negedge PCLK);
    cap = cyc;
    byte_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge PCLK);
    n_cmp++;
    if ({PSEL, PENABLE, PWRITE} !== 3'b000) begin
      $display("FAIL reset_ctl: psel/penable/pwrite=%b want 000", {PSEL, PENABLE, PWRITE}); n_bad++;
    end
    n_cmp++;
    if ({PADDR, PWDATA} !== 28'h0) begin
      $display("FAIL reset_bus: paddr=%h pwdata=%h want 0/0", PADDR, PWDATA); n_bad++;
    end
    n_cmp++;
    if ({byte_ready, init_done, tx_stall} !== 3'b000) begin
      $display("FAIL reset_status: ready/init/stall=%b want 000", {byte_ready, init_done, tx_stall}); n_bad++;
    end
  endtask

  task automatic test_init();
    logic [11:0] ea[4];
    logic [15:0] ed[4];
    int icyc;
    ea = '{12'h024, 12'h028, 12'h02C, 12'h030};
    ed = '{16'd27, 16'd8, 16'h0070, 16'h0301};
    log_q.delete();
    PRESET = 1'b0;
    wait_init(icyc);
    n_cmp++;
    if (log_q.size() != 4) begin $display("FAIL init_count: %0d transfers want 4", log_q.size()); n_bad++; end
    for (int i = 0; i < 4; i++) begin
      if (log_q.size() > i) begin
        n_cmp++;
        if ({log_q[i].wr, log_q[i].addr, log_q[i].data} !== {1'b1, ea[i], ed[i]}) begin
          $display("FAIL init_wr%0d: wr=%b addr=%h data=%h want 1/%h/%h", i,
                   log_q[i].wr, log_q[i].addr, log_q[i].data, ea[i], ed[i]);
          n_bad++;
        end
      end
    end
    if (log_q.size() == 4) begin
      n_cmp++;
      if (log_q[3].cyc - log_q[0].cyc != 6) begin
        $display("FAIL init_spacing: %0d cycles want 6", log_q[3].cyc - log_q[0].cyc); n_bad++;
      end
      n_cmp++;
      if (icyc - log_q[3].cyc != 1) begin
        $display("FAIL init_done_lat: %0d want 1", icyc - log_q[3].cyc); n_bad++;
      end
    end
    n_cmp++;
    if (byte_ready !== 1'b1) begin $display("FAIL init_ready: byte_ready=%b want 1", byte_ready); n_bad++; end
    n_cmp++;
    if (proto_err != 0) begin $display("FAIL init_proto: %0d violations want 0", proto_err); n_bad++; end
  endtask

  task automatic test_single_byte();
    int cap, t, nrd, nwr;
    log_q.delete();
    busy_until = rd_cnt;
    put_byte(8'h41, cap);
    t = 0;
    while (!byte_ready && t < 20) begin @(negedge PCLK); t++; end
    n_cmp++;
    if (cyc - cap != EXP_LAT) begin $display("FAIL single_lat: %0d cycles want %0d", cyc - cap, EXP_LAT); n_bad++; end
    repeat (3) @(negedge PCLK);
    count_log(nrd, nwr);
    n_cmp++;
    if (nwr != 1 || nrd != EXP_RD || log_q.size() != 1 + EXP_RD) begin
      $display("FAIL single_count: wr=%0d rd=%0d total=%0d want 1/%0d/%0d", nwr, nrd, log_q.size(), EXP_RD, 1 + EXP_RD);
      n_bad++;
    end
    if (log_q.size() == 1 + EXP_RD) begin
      n_cmp++;
      if ({log_q[EXP_RD].addr, log_q[EXP_RD].data} !== {12'h000, 16'h0041}) begin
        $display("FAIL single_data: addr=%h data=%h want 000/0041", log_q[EXP_RD].addr, log_q[EXP_RD].data); n_bad++;
      end
      n_cmp++;
      if (log_q[EXP_RD].cyc - cap != EXP_WRLAT) begin
        $display("FAIL single_wrlat: %0d want %0d", log_q[EXP_RD].cyc - cap, EXP_WRLAT); n_bad++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int t, nrd, nwr;
    log_q.delete();
    busy_until = rd_cnt;
    t = 0;
    while (!byte_ready && t < 20) begin @(negedge PCLK); t++; end
    byte_in = 8'h55; byte_valid = 1'b1;
    @(negedge PCLK);
    byte_in = 8'hAA;
    t = 0;
    while (!byte_ready && t < 20) begin @(negedge PCLK); t++; end
    @(negedge PCLK);
    byte_valid = 1'b0;
    repeat (8) @(negedge PCLK);
    count_log(nrd, nwr);
    n_cmp++;
    if (nwr != 2 || nrd != 2 * EXP_RD) begin
      $display("FAIL b2b_count: wr=%0d rd=%0d want 2/%0d", nwr, nrd, 2 * EXP_RD); n_bad++;
    end
    if (log_q.size() == 2 + 2 * EXP_RD) begin
      n_cmp++;
      if (log_q[EXP_RD].data !== 16'h0055 || log_q[2 * EXP_RD + 1].data !== 16'h00AA) begin
        $display("FAIL b2b_data: %h %h want 0055 00AA", log_q[EXP_RD].data, log_q[2 * EXP_RD + 1].data); n_bad++;
      end
      n_cmp++;
      if (log_q[2 * EXP_RD + 1].cyc - log_q[EXP_RD].cyc != EXP_GAP) begin
        $display("FAIL b2b_gap: %0d cycles want %0d", log_q[2 * EXP_RD + 1].cyc - log_q[EXP_RD].cyc, EXP_GAP); n_bad++;
      end
    end
    n_cmp++;
    if (proto_err != 0) begin $display("FAIL b2b_proto: %0d violations want 0", proto_err); n_bad++; end
  endtask

`ifdef UART_TX_STREAMER_FLOWCTL_EN
  task automatic test_busy_poll();
    int cap, nrd, nwr;
    logic seen_stall = 1'b0;
    log_q.delete();
    busy_until = rd_cnt + 3;
    put_byte(8'h5A, cap);
    repeat (20) begin @(negedge PCLK); if (tx_stall) seen_stall = 1'b1; end
    count_log(nrd, nwr);
    n_cmp++;
    if (nrd != 4 || nwr != 1) begin $display("FAIL busy_count: rd=%0d wr=%0d want 4/1", nrd, nwr); n_bad++; end
    if (log_q.size() == 5) begin
      n_cmp++;
      if (log_q[4].data !== 16'h005A) begin $display("FAIL busy_data: %h want 005A", log_q[4].data); n_bad++; end
    end
    n_cmp++;
    if (seen_stall !== 1'b0) begin $display("FAIL busy_stall: tx_stall seen=%b want 0", seen_stall); n_bad++; end
  endtask

  task automatic test_stall();
    int cap, base, t, nrd, nwr;
    log_q.delete();
    base = rd_cnt;
    busy_until = rd_cnt + 1000;
    put_byte(8'hC3, cap);
    t = 0;
    while (rd_cnt - base < 3 && t < 50) begin @(negedge PCLK); t++; end
    n_cmp++;
    if (tx_stall !== 1'b0) begin $display("FAIL stall_early: tx_stall=%b after 3 polls want 0", tx_stall); n_bad++; end
    t = 0;
    while (rd_cnt - base < 4 && t < 50) begin @(negedge PCLK); t++; end
    n_cmp++;
    if (tx_stall !== 1'b1) begin $display("FAIL stall_rise: tx_stall=%b after 4 polls want 1", tx_stall); n_bad++; end
    repeat (6) @(negedge PCLK);
    count_log(nrd, nwr);
    n_cmp++;
    if (nwr != 0 || tx_stall !== 1'b1) begin
      $display("FAIL stall_hold: wr=%0d tx_stall=%b want 0/1", nwr, tx_stall); n_bad++;
    end
    busy_until = rd_cnt;
    repeat (10) @(negedge PCLK);
    count_log(nrd, nwr);
    n_cmp++;
    if (nwr != 1 || log_q[log_q.size() - 1].data !== 16'h00C3) begin
      $display("FAIL stall_release: wr=%0d last=%h want 1/00C3", nwr, log_q[log_q.size() - 1].data); n_bad++;
    end
    n_cmp++;
    if (tx_stall !== 1'b0) begin $display("FAIL stall_fall: tx_stall=%b want 0", tx_stall); n_bad++; end
  endtask
`endif

  task automatic test_reset_mid();
    int cap, t, icyc, nrd, nwr;
    log_q.delete();
    busy_until = rd_cnt;
    put_byte(8'h99, cap);
    t = 0;
    while (!(PSEL && PENABLE && PWRITE && PADDR == 12'h000) && t < 20) begin @(negedge PCLK); t++; end
    PRESET = 1'b1;
    #1;
    n_cmp++;
    if ({PSEL, PENABLE, init_done} !== 3'b000) begin
      $display("FAIL mid_abort: psel/penable/init=%b want 000", {PSEL, PENABLE, init_done}); n_bad++;
    end
    repeat (2) @(negedge PCLK);
    count_log(nrd, nwr);
    n_cmp++;
    if (nwr != 0) begin $display("FAIL mid_nowrite: %0d DR writes want 0", nwr); n_bad++; end
    log_q.delete();
    PRESET = 1'b0;
    wait_init(icyc);
    n_cmp++;
    if (log_q.size() != 4 || log_q[0].addr !== 12'h024) begin
      $display("FAIL mid_restart: %0d transfers first=%h want 4/024", log_q.size(), log_q.size() ? log_q[0].addr : 12'h0);
      n_bad++;
    end
    repeat (10) @(negedge PCLK);
    count_log(nrd, nwr);
    n_cmp++;
    if (nwr != 0 || byte_ready !== 1'b1) begin
      $display("FAIL mid_discard: wr=%0d ready=%b want 0/1", nwr, byte_ready); n_bad++;
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_single_byte();
    test_back_to_back();
`ifdef UART_TX_STREAMER_FLOWCTL_EN
    test_busy_poll();
    test_stall();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
